matvec_call_scheduler: RTL

Shares a single `matvec` HLS component among `NUM_REQ` requesters. Requesters submit jobs, each made of three 64-bit pointers (M, V, Out0). The block picks one job at a time by round-robin, drives the component's call interface, waits for its return, and reports completion with the winning requester's ID. Only one call is outstanding at any time. The block sits between the host-side job queues and the `matvec` component's call/return ports.

---
 rtl/matvec_sched_pkg.sv | 14 +
 rtl/matvec_rr_arbiter.sv | 34 +++
 rtl/matvec_call_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/matvec_sched_pkg.sv
// Shared types and constants for the matvec call scheduler.
package matvec_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETURN
    } state_e;

    localparam int MV_ADDR_W = 64;
    localparam int WD_CNT_W  = 32;

endpackage

// File: rtl/matvec_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module matvec_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        // Upper pass covers [ptr, NUM_REQ); the lower pass picks up the wrap.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[i] && (i >= int'(i_ptr))) begin
                o_any    = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[i]) begin
                o_any    = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/matvec_call_scheduler.sv
// Round-robin scheduler sharing one matvec component among NUM_REQ requesters.
// Optional watchdog on the return wait: define MATVEC_SCHED_TIMEOUT_EN.
module matvec_call_scheduler
    import matvec_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*MV_ADDR_W-1:0]   req_m,
    input  logic [NUM_REQ*MV_ADDR_W-1:0]   req_v,
    input  logic [NUM_REQ*MV_ADDR_W-1:0]   req_out,
    output logic                           mv_start,
    input  logic                           mv_busy,
    output logic [MV_ADDR_W-1:0]           mv_M,
    output logic [MV_ADDR_W-1:0]           mv_V,
    output logic [MV_ADDR_W-1:0]           mv_Out0,
    input  logic                           mv_done,
    output logic                           mv_stall,
    output logic                           cmp_valid,
    input  logic                           cmp_ready,
    output logic [ID_W-1:0]                cmp_id,
    output logic                           cmp_err
);

    state_e                 r_state;
    logic [ID_W-1:0]        r_rr_ptr;
    logic                   r_mv_start;
    logic                   r_mv_stall;
    logic                   r_cmp_valid;
    logic [ID_W-1:0]        r_cmp_id;
    logic [MV_ADDR_W-1:0]   r_m, r_v, r_o;

    logic [NUM_REQ-1:0]     w_gnt;
    logic [ID_W-1:0]        w_gidx;
    logic                   w_any;
    logic [ID_W-1:0]        w_nxt_ptr;
    logic [MV_ADDR_W-1:0]   w_m, w_v, w_o;

    matvec_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    // One-hot grant selects the winner's pointers without a variable part-select.
    always_comb begin
        w_m = '0;
        w_v = '0;
        w_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_m = req_m[i*MV_ADDR_W +: MV_ADDR_W];
                w_v = req_v[i*MV_ADDR_W +: MV_ADDR_W];
                w_o = req_out[i*MV_ADDR_W +: MV_ADDR_W];
            end
        end
    end

    assign w_nxt_ptr = (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
    assign req_ready = (r_state == ST_IDLE) ? w_gnt : '0;

`ifdef MATVEC_SCHED_TIMEOUT_EN
    logic [WD_CNT_W-1:0] r_wd_cnt;
    logic                r_cmp_err;
    assign cmp_err = r_cmp_err;
`else
    assign cmp_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_mv_start  <= 1'b0;
            r_mv_stall  <= 1'b1;
            r_cmp_valid <= 1'b0;
            r_cmp_id    <= '0;
            r_m         <= '0;
            r_v         <= '0;
            r_o         <= '0;
`ifdef MATVEC_SCHED_TIMEOUT_EN
            r_wd_cnt    <= '0;
            r_cmp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_m        <= w_m;
                        r_v        <= w_v;
                        r_o        <= w_o;
                        r_cmp_id   <= w_gidx;
                        r_rr_ptr   <= w_nxt_ptr;
                        r_mv_start <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!mv_busy) begin
                        r_mv_start <= 1'b0;
                        r_mv_stall <= 1'b0;
                        r_state    <= ST_WAIT;
`ifdef MATVEC_SCHED_TIMEOUT_EN
                        r_wd_cnt   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    // A real return beats the watchdog when both land together.
                    if (mv_done) begin
                        r_mv_stall  <= 1'b1;
                        r_cmp_valid <= 1'b1;
                        r_state     <= ST_RETURN;
`ifdef MATVEC_SCHED_TIMEOUT_EN
                        r_cmp_err   <= 1'b0;
                    end else if (r_wd_cnt == WD_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_mv_stall  <= 1'b1;
                        r_cmp_valid <= 1'b1;
                        r_cmp_err   <= 1'b1;
                        r_state     <= ST_RETURN;
                    end else begin
                        r_wd_cnt    <= r_wd_cnt + 1'b1;
`endif
                    end
                end
                ST_RETURN: begin
                    if (cmp_ready) begin
                        r_cmp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mv_start  = r_mv_start;
    assign mv_stall  = r_mv_stall;
    assign mv_M      = r_m;
    assign mv_V      = r_v;
    assign mv_Out0   = r_o;
    assign cmp_valid = r_cmp_valid;
    assign cmp_id    = r_cmp_id;

endmodule
